// File: rtl/a2d_serf_if.sv
// a2d_serf_if: SPI bus between the A2D monarch and the serf model.
interface a2d_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    modport monarch (output SS_n, SCLK, MOSI, input MISO);
    modport serf (input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/a2d_serf.sv
// a2d_serf: SPI serf model of an 8-channel A2D; each 16-bit frame commands a channel
// and returns the 12-bit conversion of the channel commanded by the previous frame.
module a2d_serf (
    input  logic        clk,
    input  logic        rst,
    a2d_serf_if.serf    spi,
    input  logic [11:0] lft_val,
    input  logic [11:0] rght_val,
    input  logic [11:0] steer_val,
    input  logic [11:0] batt_val,
    output logic [2:0]  cmd_ch,
    output logic        cmd_vld,
    output logic        bad_ch,
    output logic        frame_err
);
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  ss_q, sclk_q;
    logic [1:0]  mosi_q;
    logic [15:0] tx_q, tx_d;
    logic [13:0] rx_q, rx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  ch_q, ch_d;
    logic        vld_q, vld_d, bad_q, bad_d, ferr_q, ferr_d;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [11:0] sel_val;

    // SS_n chain resets low so a frame already running at reset release shows no falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q   <= 3'b000;
            sclk_q <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            ss_q   <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[0], spi.MOSI};
        end
    end

    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];

    assign sel_val = (ch_q == 3'd0) ? lft_val :
                     (ch_q == 3'd4) ? rght_val :
                     (ch_q == 3'd5) ? steer_val :
                     (ch_q == 3'd6) ? batt_val : 12'h000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
            bad_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
            bad_q   <= bad_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        vld_d   = 1'b0;
        bad_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: if (ss_fall) begin
                tx_d    = {4'h0, sel_val};
                cnt_d   = '0;
                state_d = ARMED;
            end
            ARMED: if (sclk_rise) begin
                rx_d    = {rx_q[12:0], mosi_q[1]};
                cnt_d   = 5'd1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_d  = {rx_q[12:0], mosi_q[1]};
                    cnt_d = (cnt_q == 5'd17) ? 5'd17 : cnt_q + 5'd1;
                end
                if (sclk_fall) tx_d = {tx_q[14:0], 1'b0};
            end
            default: state_d = IDLE;
        endcase
        // frame end wins over any SCLK edge seen in the same cycle
        if (state_q != IDLE && ss_rise) begin
            state_d = IDLE;
            if (cnt_q == 5'd16) begin
                ch_d  = rx_q[13:11];
                vld_d = 1'b1;
                bad_d = !(rx_q[13:11] inside {3'd0, 3'd4, 3'd5, 3'd6});
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    assign spi.MISO  = ~ss_q[2] & tx_q[15];
    assign cmd_ch    = ch_q;
    assign cmd_vld   = vld_q;
    assign bad_ch    = bad_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_a2d_serf.sv
// tb_a2d_serf: random-timed SPI monarch driving a2d_serf, checked against a frame-level model.
module tb_a2d_serf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_val = 12'h123, rght_val = 12'h456, steer_val = 12'h789, batt_val = 12'hABC;
    logic [2:0]  cmd_ch;
    logic        cmd_vld, bad_ch, frame_err;
    int          checks = 0, errors = 0;
    int          n_vld, n_bad, n_ferr, n_both;
    logic [2:0]  m_ch = 3'd0;

    a2d_serf_if bus ();

    a2d_serf dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (bus.serf),
        .lft_val   (lft_val),
        .rght_val  (rght_val),
        .steer_val (steer_val),
        .batt_val  (batt_val),
        .cmd_ch    (cmd_ch),
        .cmd_vld   (cmd_vld),
        .bad_ch    (bad_ch),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_vld  += int'(cmd_vld);
            n_bad  += int'(bad_ch);
            n_ferr += int'(frame_err);
            n_both += int'(cmd_vld & bad_ch);
        end
    endtask

    function automatic int ph();
        return int'($urandom_range(6, 9));
    endfunction

    function automatic logic [11:0] val_of(input logic [2:0] ch);
        case (ch)
            3'd0:    return lft_val;
            3'd4:    return rght_val;
            3'd5:    return steer_val;
            3'd6:    return batt_val;
            default: return 12'h000;
        endcase
    endfunction

    // One frame of nr SCLK rises; batt_val is replaced just before rise chg_at (if in range).
    task automatic frame(input logic [15:0] cmd, input int nr, input int chg_at, input logic [11:0] chg_val);
        logic [15:0] exp_w, got;
        logic [2:0]  c;
        int          n;
        exp_w = {4'h0, val_of(m_ch)};
        got = '0;
        n_vld = 0; n_bad = 0; n_ferr = 0; n_both = 0;
        bus.SS_n = 1'b0;
        bus.MOSI = cmd[15];
        tick(ph());
        for (int i = 0; i < nr; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            if (i == chg_at) batt_val = chg_val;
            tick(ph());
            if (i < 16) got = {got[14:0], bus.MISO};
            bus.SCLK = 1'b1;
            tick(ph());
        end
        bus.SS_n = 1'b1;
        tick(10);
        n = (nr < 16) ? nr : 16;
        chk("miso_word", 32'(got), 32'(exp_w >> (16 - n)));
        c = cmd[13:11];
        if (nr == 16) begin
            m_ch = c;
            chk("cmd_vld", n_vld, 1);
            chk("bad_ch", n_bad, (c == 3'd0 || c == 3'd4 || c == 3'd5 || c == 3'd6) ? 0 : 1);
            chk("bad_with_vld", n_both, n_bad);
            chk("frame_err", n_ferr, 0);
        end else begin
            chk("cmd_vld", n_vld, 0);
            chk("bad_ch", n_bad, 0);
            chk("frame_err", n_ferr, 1);
        end
        chk("cmd_ch", 32'(cmd_ch), 32'(m_ch));
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        bus.MOSI = 1'b0;
        n_vld = 0; n_bad = 0; n_ferr = 0; n_both = 0;
        tick(3);
        chk("rst_miso", 32'(bus.MISO), 0);
        chk("rst_cmd_ch", 32'(cmd_ch), 0);
        chk("rst_vld", 32'(cmd_vld), 0);
        chk("rst_bad", 32'(bad_ch), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        rst = 1'b0;
        tick(6);

        frame(16'h2000, 16, -1, 12'h0);
        frame(16'h2800, 16, -1, 12'h0);
        frame(16'h3000, 16, -1, 12'h0);
        frame(16'h0000, 16, -1, 12'h0);
        frame(16'h2000, 16, -1, 12'h0);
        frame(16'h0800, 16, -1, 12'h0);
        frame(16'h2000, 16, -1, 12'h0);
        frame(16'h3000, 8, -1, 12'h0);
        frame(16'h3000, 16, -1, 12'h0);
        frame(16'h3000, 16, 8, 12'h5A5);
        frame(16'h3000, 16, -1, 12'h0);
        frame(16'h2800, 18, -1, 12'h0);
        batt_val = 12'hABC;
        tick(4);

        // reset pulsed in the middle of a frame with SS_n held low
        n_vld = 0; n_bad = 0; n_ferr = 0; n_both = 0;
        bus.SS_n = 1'b0;
        tick(ph());
        for (int i = 0; i < 16; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = 1'b1;
            tick(ph());
            if (i == 5) begin
                rst = 1'b1;
                tick(1);
                chk("midrst_miso", 32'(bus.MISO), 0);
                chk("midrst_cmd_ch", 32'(cmd_ch), 0);
                tick(1);
                rst = 1'b0;
            end
            bus.SCLK = 1'b1;
            tick(ph());
        end
        bus.SS_n = 1'b1;
        tick(10);
        m_ch = 3'd0;
        chk("midrst_vld", n_vld, 0);
        chk("midrst_ferr", n_ferr, 0);
        chk("midrst_bad", n_bad, 0);
        chk("midrst_cmd_ch_end", 32'(cmd_ch), 0);
        frame(16'h2000, 16, -1, 12'h0);

        for (int k = 0; k < 24; k++) begin
            int nr;
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 18)) : 16;
            case ($urandom_range(0, 4))
                0: lft_val = 12'($urandom);
                1: rght_val = 12'($urandom);
                2: steer_val = 12'($urandom);
                3: batt_val = 12'($urandom);
                default: ;
            endcase
            tick(ph());
            frame(16'($urandom), nr, -1, 12'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
